// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register Tnew countdowns, a multiply/divide
// busy countdown, and a saturating stall-cycle counter.

module hazard_reg_cnt #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] tnew,
  output logic [TW-1:0] cnt
);
  // A fresh write overrides the running decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= tnew;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int MDW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_use,
  input  logic          d_rt_use,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic [1:0]    d_md_start,
  input  logic          d_md_use,
  input  logic          d_flush,
  output logic          stall,
  output logic [31:0]   stall_cnt
);
  // Register 0 has no counter; it always reads as ready.
  logic [NREG-1:1][TW-1:0] cnt;
  logic [TW-1:0]           rs_cnt, rt_cnt;
  logic [MDW-1:0]          md_cnt;
  logic                    haz_rs, haz_rt, haz_md, issue, wr_en;

  // Out-of-range write addresses match no counter and are dropped.
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    hazard_reg_cnt #(.TW(TW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (wr_en && (d_wa == AW'(r))),
      .tnew  (d_tnew),
      .cnt   (cnt[r])
    );
  end

  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (d_rs == AW'(r)) rs_cnt = cnt[r];
      if (d_rt == AW'(r)) rt_cnt = cnt[r];
    end
  end

  assign haz_rs = d_rs_use && (d_rs != '0) && (rs_cnt > d_tuse_rs);
  assign haz_rt = d_rt_use && (d_rt != '0) && (rt_cnt > d_tuse_rt);
  assign haz_md = d_md_use && (md_cnt != '0);
  assign stall  = d_valid && !d_flush && !reset && (haz_rs || haz_rt || haz_md);
  assign issue  = d_valid && !d_flush && !stall;
  assign wr_en  = issue && d_we && (d_wa != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             md_cnt <= '0;
    else if (issue && d_md_start == 2'd1)  md_cnt <= MDW'(MULT_LAT);
    else if (issue && d_md_start == 2'd2)  md_cnt <= MDW'(DIV_LAT);
    else if (md_cnt != '0)                 md_cnt <= md_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus a randomized run
// against an absolute-time readiness model.

module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_rs_use, d_rt_use, d_we, d_md_use, d_flush;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
  logic        stall;
  logic [31:0] stall_cnt;

  int cmp_n = 0;
  int err_n = 0;

  // Model: each register / the MD unit is ready at an absolute cycle number.
  int     cyc = 0;
  int     ready [32];
  int     md_ready = 0;
  longint sc_m = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_use(d_md_use), .d_flush(d_flush),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_stall();
    int rem_rs, rem_rt;
    if (rst || !d_valid || d_flush) return 1'b0;
    rem_rs = ready[d_rs] - cyc;
    rem_rt = ready[d_rt] - cyc;
    if (d_rs_use && d_rs != 0 && rem_rs > int'(d_tuse_rs)) return 1'b1;
    if (d_rt_use && d_rt != 0 && rem_rt > int'(d_tuse_rt)) return 1'b1;
    if (d_md_use && md_ready > cyc) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge; the model advances alongside, then inputs may change at negedge.
  task automatic tick();
    bit es, iss;
    es  = model_stall();
    iss = d_valid && !d_flush && !es && !rst;
    @(posedge clk);
    if (rst) begin
      foreach (ready[i]) ready[i] = 0;
      md_ready = 0;
      sc_m = 0;
    end else begin
      if (es) sc_m++;
      if (iss && d_we && d_wa != 0) ready[d_wa] = cyc + 1 + int'(d_tnew);
      if (iss && d_md_start == 2'd1) md_ready = cyc + 1 + 5;
      if (iss && d_md_start == 2'd2) md_ready = cyc + 1 + 10;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    d_valid = 0; d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0;
    d_tuse_rs = 0; d_tuse_rt = 0; d_we = 0; d_wa = 0; d_tnew = 0;
    d_md_start = 0; d_md_use = 0; d_flush = 0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic issue_wr(input logic [4:0] wa, input logic [1:0] tn);
    clr();
    d_valid = 1; d_we = 1; d_wa = wa; d_tnew = tn;
    tick();
  endtask

  task automatic consumer(input logic [4:0] rs, input logic [1:0] tu);
    clr();
    d_valid = 1; d_rs = rs; d_rs_use = 1; d_tuse_rs = tu;
  endtask

  // Holds current D inputs until the instruction issues; returns stall cycles seen.
  task automatic run_until_issue(output int n, output bit to);
    n = 0; to = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall === 1'b0) begin
        to = 0;
        tick();
        break;
      end
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1; clr();
    d_valid = 1; d_md_use = 1; d_rs = 5'd3; d_rs_use = 1;
    #1;
    cmp_n++;
    if (stall !== 1'b0) begin err_n++; $display("FAIL reset_stall got=%b want=0", stall); end
    cmp_n++;
    if (stall_cnt !== 32'd0) begin err_n++; $display("FAIL reset_stall_cnt got=%h want=0", stall_cnt); end
    tick();
    rst = 0;
    idle(1);
  endtask

  task automatic test_load_use();
    int n; bit to;
    issue_wr(5'd8, 2'd2);
    consumer(5'd8, 2'd1);
    d_rt = 5'd1; d_rt_use = 1; d_tuse_rt = 2'd1; d_we = 1; d_wa = 5'd9; d_tnew = 2'd1;
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 1) begin err_n++; $display("FAIL load_use stalls got=%0d to=%b want=1", n, to); end
    idle(4);
  endtask

  task automatic test_load_branch();
    int n; bit to;
    issue_wr(5'd8, 2'd2);
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 2) begin err_n++; $display("FAIL load_branch stalls got=%0d to=%b want=2", n, to); end
    idle(4);
    issue_wr(5'd8, 2'd1);
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 1) begin err_n++; $display("FAIL alu_branch stalls got=%0d to=%b want=1", n, to); end
    idle(4);
    issue_wr(5'd31, 2'd0);
    consumer(5'd31, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 0) begin err_n++; $display("FAIL jal_jr stalls got=%0d to=%b want=0", n, to); end
    idle(4);
  endtask

  task automatic test_zero_reg();
    int n; bit to;
    issue_wr(5'd0, 2'd3);
    consumer(5'd0, 2'd0);
    d_rt = 5'd0; d_rt_use = 1; d_we = 1; d_wa = 5'd1; d_tnew = 2'd1;
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 0) begin err_n++; $display("FAIL zero_reg stalls got=%0d to=%b want=0", n, to); end
    idle(4);
  endtask

  task automatic test_md();
    int n; bit to;
    logic [31:0] s0;
    clr(); d_valid = 1; d_md_use = 1; d_md_start = 2'd1; tick();
    clr(); d_valid = 1; tick();
    clr(); d_valid = 1; d_md_use = 1;
    s0 = stall_cnt;
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 4) begin err_n++; $display("FAIL mult_mflo stalls got=%0d to=%b want=4", n, to); end
    cmp_n++;
    if (stall_cnt - s0 !== 32'd4) begin err_n++; $display("FAIL mult_stall_cnt delta got=%0d want=4", stall_cnt - s0); end
    idle(12);
    clr(); d_valid = 1; d_md_use = 1; d_md_start = 2'd2; tick();
    clr(); d_valid = 1; tick();
    clr(); d_valid = 1; d_md_use = 1; d_md_start = 2'd2;
    s0 = stall_cnt;
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 9) begin err_n++; $display("FAIL div_div stalls got=%0d to=%b want=9", n, to); end
    cmp_n++;
    if (stall_cnt - s0 !== 32'd9) begin err_n++; $display("FAIL div_stall_cnt delta got=%0d want=9", stall_cnt - s0); end
    idle(12);
  endtask

  task automatic test_flush();
    int n; bit to;
    issue_wr(5'd8, 2'd2);
    consumer(5'd8, 2'd1);
    d_flush = 1; d_we = 1; d_wa = 5'd9; d_tnew = 2'd3;
    #1;
    cmp_n++;
    if (stall !== 1'b0) begin err_n++; $display("FAIL flush_stall got=%b want=0", stall); end
    tick();
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 1) begin err_n++; $display("FAIL flush_decay stalls got=%0d to=%b want=1", n, to); end
    consumer(5'd9, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 0) begin err_n++; $display("FAIL flush_no_issue stalls got=%0d to=%b want=0", n, to); end
    idle(4);
  endtask

  task automatic test_reset_mid_md();
    clr(); d_valid = 1; d_md_use = 1; d_md_start = 2'd1; tick();
    clr(); d_valid = 1; d_md_use = 1;
    #1;
    cmp_n++;
    if (stall !== 1'b1) begin err_n++; $display("FAIL md_busy_stall got=%b want=1", stall); end
    tick();
    #2 rst = 1;
    #1;
    cmp_n++;
    if (stall !== 1'b0) begin err_n++; $display("FAIL async_reset_stall got=%b want=0", stall); end
    cmp_n++;
    if (stall_cnt !== 32'd0) begin err_n++; $display("FAIL async_reset_stall_cnt got=%h want=0", stall_cnt); end
    tick();
    rst = 0;
    #1;
    cmp_n++;
    if (stall !== 1'b0) begin err_n++; $display("FAIL post_reset_md got=%b want=0", stall); end
    tick();
    idle(2);
  endtask

  task automatic test_overwrite();
    int n; bit to;
    issue_wr(5'd8, 2'd2);
    issue_wr(5'd8, 2'd1);
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 1) begin err_n++; $display("FAIL overwrite_lower stalls got=%0d to=%b want=1", n, to); end
    idle(4);
    issue_wr(5'd8, 2'd1);
    issue_wr(5'd8, 2'd3);
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 3) begin err_n++; $display("FAIL overwrite_higher stalls got=%0d to=%b want=3", n, to); end
    idle(4);
  endtask

  task automatic test_random();
    bit es;
    rst = 1; clr(); tick();
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      d_valid    = ($urandom_range(0, 9) != 0);
      d_flush    = ($urandom_range(0, 15) == 0);
      d_rs       = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      d_rt       = 5'($urandom_range(0, 7));
      d_rs_use   = 1'($urandom);
      d_rt_use   = 1'($urandom);
      d_tuse_rs  = 2'($urandom);
      d_tuse_rt  = 2'($urandom);
      d_we       = 1'($urandom);
      d_wa       = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      d_tnew     = 2'($urandom);
      d_md_start = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'd0;
      d_md_use   = (d_md_start != 0) || ($urandom_range(0, 7) == 0);
      #1;
      es = model_stall();
      cmp_n++;
      if (stall !== es) begin err_n++; $display("FAIL random_stall cyc=%0d got=%b want=%b", cyc, stall, es); end
      tick();
    end
    cmp_n++;
    if (stall_cnt !== sc_m[31:0]) begin err_n++; $display("FAIL random_stall_cnt got=%0d want=%0d", stall_cnt, sc_m); end
    idle(12);
  endtask

  task automatic test_saturation();
    int n; bit to;
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt;
    issue_wr(5'd8, 2'd3);
    consumer(5'd8, 2'd0);
    run_until_issue(n, to);
    cmp_n++;
    if (to || n != 3) begin err_n++; $display("FAIL sat_stalls got=%0d to=%b want=3", n, to); end
    cmp_n++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin err_n++; $display("FAIL stall_cnt_saturate got=%h want=ffffffff", stall_cnt); end
  endtask

  initial begin
    foreach (ready[i]) ready[i] = 0;
    rst = 1; clr();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_load_branch();
    test_zero_reg();
    test_md();
    test_flush();
    test_reset_mid_md();
    test_overwrite();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the decode-stage stall unit of the MIPS pipeline. It replaces the per-pair comparison of D against the E and M instruction words with a per-register scoreboard. Each pending destination register carries a countdown of cycles until its result can be forwarded. Decode stalls when a source operand's remaining latency exceeds the cycles before the instruction needs it (Tnew > Tuse). A second countdown tracks a multiply/divide unit with configurable latencies, and a saturating counter records stall cycles for performance analysis.

## Interface
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; ceil(log2(NREG)).
- TW, 2, width of all Tnew/Tuse fields and per-register counters.
- MULT_LAT, 5, cycles the MD unit stays busy after a mult issues.
- DIV_LAT, 10, cycles the MD unit stays busy after a div issues.
- MDW, 4, MD countdown width; must satisfy 2^MDW-1 >= max(MULT_LAT, DIV_LAT).
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- d_valid  in  1  D stage holds a real instruction; 0 means bubble.
- d_rs, d_rt  in  AW  source register addresses.
- d_rs_use, d_rt_use  in  1  the corresponding source is actually read.
- d_tuse_rs, d_tuse_rt  in  TW  cycles after D before the value is consumed (branch/jr = 0, ALU = 1, store data = 2).
- d_we  in  1  instruction writes a GPR.
- d_wa  in  AW  destination address.
- d_tnew  in  TW  cycles after issue until the result is forwardable (ALU = 1, load = 2, jal = 0).
- d_md_start  in  2  0 = none, 1 = mult, 2 = div, 3 = reserved, treated as none.
- d_md_use  in  1  instruction needs the MD unit (mfhi, mflo, mthi, mtlo, mult, div).
- d_flush  in  1  D instruction is being killed this cycle.
- stall  out  1  freeze PC and F/D; insert a bubble into E.
- stall_cnt  out  32  saturating count of cycles with stall=1.

## Operation
- State:
  - cnt[r] (TW bits) for r in 1..NREG-1.
  - md_cnt (MDW bits).
  - stall_cnt.
- Source hazard: haz_rs = d_rs_use & (d_rs != 0) & (cnt[d_rs] > d_tuse_rs). haz_rt is the same with the rt fields.
- MD hazard: haz_md = d_md_use & (md_cnt != 0).
- stall = d_valid & !d_flush & !reset & (haz_rs | haz_rt | haz_md). The output is combinational from state and D inputs.
- issue = d_valid & !d_flush & !stall.
- Each clock edge:
  - Every nonzero cnt[r] decrements by 1, saturating at 0.
  - Then, if issue & d_we & (d_wa != 0), cnt[d_wa] = d_tnew. The new value overrides the decrement.
- Writes to register 0 are ignored. Reads of register 0 never stall.
- md_cnt:
  - On issue with d_md_start = 1, md_cnt = MULT_LAT.
  - On issue with d_md_start = 2, md_cnt = DIV_LAT.
  - Otherwise md_cnt decrements when nonzero.
- Flush: suppresses issue and stall. Already-pending counters keep counting, because the producers are already in E/M/W.
- stall_cnt increments on every edge where stall = 1 and holds at 0xFFFF_FFFF.
- Unused or out-of-range d_wa (>= NREG) is ignored.

## Timing
- Reset values, applied asynchronously:
  - All cnt[r] = 0, md_cnt = 0, stall_cnt = 0.
  - stall = 0 while reset is high.
- Zero-latency detection: stall is valid in the same cycle the D inputs are presented.
- Producer issued at edge n with Tnew = T:
  - The counter reads T during cycle n+1.
  - A consumer with Tuse = U stalls in cycles n+1 through n+T-U, then issues. There is no stall if T <= U.
- A stalled instruction re-evaluates every cycle with unchanged D inputs. Counters keep decrementing while stalled.
- Reset asserted mid-stall: stall drops immediately. The scoreboard is empty after reset release.
- Simultaneous issue and an existing pending write to the same register: the new Tnew wins.

## Test plan
- Load-use ALU: issue lw $8 (tnew=2), then add $9,$8,$1 (tuse_rs=1) -> stall=1 for exactly 1 cycle, add issues on the 2nd cycle.
- Load-branch: lw $8 then beq $8,$0 (tuse=0) -> stall for 2 cycles. ALU write $8 (tnew=1) then beq -> stall for 1 cycle. jal (tnew=0 to $31) then jr $31 -> no stall.
- $0 immunity: lw $0 then add $1,$0,$0 -> no stall, and cnt[0] is never set.
- MD busy: mult issued, then mflo 1 cycle later -> stall for MULT_LAT-1 = 4 cycles. div then div -> second div stalls DIV_LAT-1 = 9 cycles. stall_cnt advances by the same amounts.
- Flush/reset: lw $8, then add $9,$8 with d_flush=1 -> stall=0, add not issued, cnt[$8] still decrements to 0. Reset mid-MD-busy -> md_cnt=0, stall=0 asynchronously, stall_cnt=0.
- Overwrite/saturation: lw $8 (tnew=2), then ALU to $8 (tnew=1) issued next cycle -> cnt[$8]=1. Force 2^32 stall cycles (or preload in sim) -> stall_cnt holds 0xFFFF_FFFF.
